// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory-port arbitration; define SEQ_PERF_COUNTERS_EN to build instret/cycles counters
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_instr,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic [1:0]  fault,
  output logic [31:0] instret,
  output logic [31:0] cycles
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7} state_e;
  typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_e;
  state_e        state_q, state_d;
  cls_e          cls_q, cls_d, dec;
  logic [1:0]    fault_q, fault_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_lim;
  logic          mem_req_c, mem_we_c, mem_is_instr_c, ir_we_c, pc_we_c, rf_we_c;
  logic [1:0]    pc_sel_c, wb_sel_c;
  assign tmo_lim = tmo_q == TW'(MEM_TIMEOUT - 1);
  // Map the RISC-V major opcode to an instruction class
  always_comb begin
    case (opcode)
      7'b0110011: dec = C_R;
      7'b0010011: dec = C_I;
      7'b0000011: dec = C_LOAD;
      7'b0100011: dec = C_STORE;
      7'b1100011: dec = C_BRANCH;
      7'b1101111: dec = C_JAL;
      7'b1100111: dec = C_JALR;
      7'b0110111: dec = C_LUI;
      7'b0010111: dec = C_AUIPC;
      default:    dec = C_ILL;
    endcase
  end
  // Next-state, fault and strobe decode from registered state and class
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    fault_d = fault_q;
    mem_req_c = 1'b0;
    mem_we_c = 1'b0;
    mem_is_instr_c = 1'b0;
    ir_we_c = 1'b0;
    pc_we_c = 1'b0;
    rf_we_c = 1'b0;
    pc_sel_c = 2'd0;
    wb_sel_c = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        mem_is_instr_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_lim) begin
          fault_d = 2'b10;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        cls_d = dec;
        fault_d = (dec == C_ILL) ? 2'b01 : fault_q;
        state_d = (dec == C_ILL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        pc_we_c = cls_q == C_BRANCH;
        pc_sel_c = (cls_q == C_BRANCH && branch_taken) ? 2'd1 : 2'd0;
        state_d = (cls_q == C_BRANCH) ? S_FETCH : (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c = cls_q == C_STORE;
        if (mem_ready) begin
          pc_we_c = cls_q == C_STORE;
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        end else if (tmo_lim) begin
          fault_d = 2'b10;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        wb_sel_c = (cls_q == C_LOAD) ? 2'd1 : (cls_q == C_JAL || cls_q == C_JALR) ? 2'd2 : (cls_q == C_LUI) ? 2'd3 : 2'd0;
        pc_sel_c = (cls_q == C_JAL) ? 2'd1 : (cls_q == C_JALR) ? 2'd2 : 2'd0;
        state_d = S_FETCH;
      end
      default: ;
    endcase
    tmo_d = (state_d != state_q) ? '0 : ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) ? tmo_q + TW'(1) : tmo_q;
  end
  // State, class, sticky fault and wait-cycle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q <= C_ILL;
      fault_q <= 2'b00;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      fault_q <= fault_d;
      tmo_q <= tmo_d;
    end
  end
  assign mem_req = rst_n & mem_req_c;
  assign mem_we = rst_n & mem_we_c;
  assign mem_is_instr = rst_n & mem_is_instr_c;
  assign ir_we = rst_n & ir_we_c;
  assign pc_we = rst_n & pc_we_c;
  assign rf_we = rst_n & rf_we_c;
  assign pc_sel = rst_n ? pc_sel_c : 2'd0;
  assign wb_sel = rst_n ? wb_sel_c : 2'd0;
  assign state = state_q;
  assign fault = fault_q;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] instret_q, instret_d, cycles_q, cycles_d;
  assign instret_d = pc_we_c ? instret_q + 32'd1 : instret_q;
  assign cycles_d = cycles_q + 32'd1;
  // Free-running cycle count and retire count (one retire per pc_we pulse)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
      cycles_q <= '0;
    end else begin
      instret_q <= instret_d;
      cycles_q <= cycles_d;
    end
  end
  assign instret = instret_q;
  assign cycles = cycles_q;
`else
  assign instret = '0;
  assign cycles = '0;
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: scoreboard bench; expected retire/halt events are queued by stimulus and checked by a monitor
module tb_multicycle_sequencer;
`ifdef SEQ_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_ILL = 7'b1111111;
  logic        clk = 1'b0;
  logic        rst_n, branch_taken, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, mem_we, mem_is_instr, ir_we, pc_we, rf_we;
  logic [1:0]  pc_sel, wb_sel, fault;
  logic [2:0]  state;
  logic [31:0] instret, cycles;
  typedef struct {
    bit          halt;
    int          lat;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        rf;
    logic        we;
    logic [1:0]  fault;
    logic [31:0] instret;
  } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   nret = 0;
  int   w = 0;
  multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_instr(mem_is_instr), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .state(state), .fault(fault),
    .instret(instret), .cycles(cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t rt(input int lat, input logic [1:0] ps, input logic [1:0] wb, input logic rf, input logic we);
    exp_t e;
    e.halt = 1'b0; e.lat = lat; e.pc_sel = ps; e.wb_sel = wb; e.rf = rf; e.we = we; e.fault = 2'b00; e.instret = 0;
    return e;
  endfunction
  function automatic exp_t hl(input int lat, input logic [1:0] f);
    exp_t e;
    e = rt(lat, 2'd0, 2'd0, 1'b0, 1'b0);
    e.halt = 1'b1; e.fault = f;
    return e;
  endfunction
  // Memory model: ready after fw (fetch) or dw (data) wait cycles; idle port is driven ready to show it is ignored
  task automatic cycle(input int fw, input int dw);
    if (mem_req) begin
      if (w >= (mem_is_instr ? fw : dw)) begin
        mem_ready = 1'b1;
        w = 0;
      end else begin
        mem_ready = 1'b0;
        w++;
      end
    end else mem_ready = 1'b1;
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    w = 0;
    nret = 0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", {mem_req, mem_we, mem_is_instr, ir_we, pc_we, rf_we, pc_sel, wb_sel}, 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_instret", instret, 0);
    chk("rst_cycles", cycles, 0);
    rst_n = 1'b1;
    #1;
    chk("first_req", {mem_req, mem_is_instr}, 2'b11);
    chk("post_rst_cycles", cycles, 0);
  endtask
  task automatic run(input logic [6:0] op, input logic tk, input int fw, input int dw, input exp_t e);
    bit done = 1'b0;
    e.instret = PERF ? 32'(nret) : 32'd0;
    if (!e.halt) nret++;
    sb.push_back(e);
    opcode = op;
    branch_taken = tk;
    for (int i = 0; i < 60 && !done; i++) begin
      cycle(fw, dw);
      done = pc_we || state == 3'd7;
      @(posedge clk);
      #1;
    end
    chk($sformatf("run_bound_%b", op), 32'(done), 1);
  endtask
  // Monitor: pops one expectation per retire (pc_we) or HALT entry, checks HALT stays quiet
  initial begin
    int   lat;
    logic rf_seen, we_seen, halted;
    logic [1:0] wb_cap, hf;
    exp_t e;
    lat = 0; rf_seen = 0; we_seen = 0; halted = 0; wb_cap = 0; hf = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat = 0; rf_seen = 0; we_seen = 0; halted = 0; wb_cap = 0;
        continue;
      end
      lat++;
      if (rf_we) begin rf_seen = 1; wb_cap = wb_sel; end
      if (mem_we) we_seen = 1;
      if (pc_we || (state == 3'd7 && !halted)) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb: unexpected event in state %0d", state);
        end else begin
          e = sb.pop_front();
          chk("ev_kind", 32'(state == 3'd7), 32'(e.halt));
          chk("ev_latency", lat, e.lat);
          chk("ev_instret", instret, e.instret);
          if (e.halt) begin
            chk("halt_fault", 32'(fault), 32'(e.fault));
            hf = e.fault;
          end else begin
            chk("ret_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
            chk("ret_rf_we", 32'(rf_seen), 32'(e.rf));
            chk("ret_wb_sel", 32'(wb_cap), 32'(e.wb_sel));
            chk("ret_mem_we", 32'(we_seen), 32'(e.we));
          end
        end
        if (state == 3'd7) halted = 1;
        lat = 0; rf_seen = 0; we_seen = 0; wb_cap = 0;
      end else if (halted) begin
        chk("halt_quiet", {mem_req, mem_we, ir_we, pc_we, rf_we, state}, {5'b0, 3'd7});
        chk("halt_fault_hold", 32'(fault), 32'(hf));
      end
    end
  end
  initial begin
    rst_n = 1'b1; opcode = OP_I; branch_taken = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset();
    run(OP_I,     1'b0, 0, 0, rt(4,  2'd0, 2'd0, 1'b1, 1'b0));
    run(OP_LD,    1'b0, 0, 2, rt(7,  2'd0, 2'd1, 1'b1, 1'b0));
    run(OP_BR,    1'b1, 0, 0, rt(3,  2'd1, 2'd0, 1'b0, 1'b0));
    run(OP_BR,    1'b0, 0, 0, rt(3,  2'd0, 2'd0, 1'b0, 1'b0));
    run(OP_ST,    1'b0, 1, 0, rt(5,  2'd0, 2'd0, 1'b0, 1'b1));
    run(OP_JAL,   1'b0, 0, 0, rt(4,  2'd1, 2'd2, 1'b1, 1'b0));
    run(OP_JALR,  1'b1, 2, 0, rt(6,  2'd2, 2'd2, 1'b1, 1'b0));
    run(OP_LUI,   1'b0, 0, 0, rt(4,  2'd0, 2'd3, 1'b1, 1'b0));
    run(OP_AUIPC, 1'b0, 0, 0, rt(4,  2'd0, 2'd0, 1'b1, 1'b0));
    run(OP_R,     1'b0, 0, 0, rt(4,  2'd0, 2'd0, 1'b1, 1'b0));
    run(OP_LD,    1'b0, 3, 3, rt(11, 2'd0, 2'd1, 1'b1, 1'b0));
    run(OP_ILL,   1'b0, 0, 0, hl(3, 2'b01));
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    run(OP_I,     1'b0, 100, 0, hl(5, 2'b10));
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    opcode = OP_ST;
    for (int i = 0; i < 20 && state != 3'd3; i++) begin
      cycle(0, 10);
      @(posedge clk);
      #1;
    end
    chk("reach_mem", 32'(state), 3);
    cycle(0, 10);
    chk("store_we", {mem_req, mem_we, mem_is_instr}, 3'b110);
    chk("store_instret", instret, PERF ? 32'd0 : 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {mem_req, mem_we, mem_is_instr, ir_we, pc_we, rf_we}, 0);
    chk("abort_state", 32'(state), 0);
    chk("abort_cycles", cycles, 0);
    do_reset();
    run(OP_I,     1'b0, 0, 0, rt(4,  2'd0, 2'd0, 1'b1, 1'b0));
    run(OP_BR,    1'b1, 1, 0, rt(4,  2'd1, 2'd0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the sequential RISC-V core. It steps the shared datapath through FETCH, DECODE, EXECUTE, MEM and WB for each instruction, and arbitrates the single memory port between instruction fetch and data access. It generates the register-file, PC and IR write strobes and the PC/writeback selects. The opcode-level control decode (ALUOp, ALUSrc and related signals) stays in the existing control unit; this block decides only *when* each strobe fires.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum number of cycles to wait for mem_ready before faulting; legal range 2..255.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from the IR; sampled in DECODE.
- branch_taken  in  1  branch comparison result from the ALU; valid in EXECUTE.
- mem_ready  in  1  memory port completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write access (stores only).
- mem_is_instr  out  1  1 = instruction fetch, 0 = data access.
- ir_we  out  1  latch the fetched word into the IR.
- pc_we  out  1  update the PC.
- pc_sel  out  2  PC source: 0 = pc+4, 1 = pc+imm (branch/JAL), 2 = rs1+imm (JALR).
- rf_we  out  1  register-file write.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4, 3 = immediate (LUI).
- state  out  3  current state, for debug.
- fault  out  2  sticky fault code: 00 = none, 01 = illegal opcode, 10 = memory timeout.
- instret  out  32  retired-instruction count (see Configuration).
- cycles  out  32  cycles since reset (see Configuration).

## Operation
State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=7.

- Every strobe is decoded combinationally from the registered state and class, plus mem_ready where noted.
- While rst_n is low, all strobes are forced to 0.

FSM behaviour:
- **FETCH:** assert mem_req=1 and mem_is_instr=1.
  - On mem_ready: ir_we=1, go to DECODE.
  - Otherwise: stay in FETCH.
- **DECODE:** register the opcode class: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode: set fault=01, go to HALT.
  - Otherwise: go to EXECUTE.
- **EXECUTE** (one cycle), by class:
  - BRANCH: pc_we=1; pc_sel=1 if branch_taken, else 0; retire; go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- **MEM:** mem_req=1, mem_is_instr=0, mem_we=1 for STORE only. Hold until mem_ready. When mem_ready is high:
  - STORE: pc_we=1, pc_sel=0, retire, go to FETCH.
  - LOAD: go to WB.
- **WB:** rf_we=1 and pc_we=1, then go to FETCH. Selects by class:
  - R, I, AUIPC: wb_sel=0, pc_sel=0.
  - LOAD: wb_sel=1, pc_sel=0.
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2.
  - LUI: wb_sel=3, pc_sel=0.
- **HALT:** all strobes 0; fault holds its value. Exit only via rst_n.

Timeout counter:
- Width is $clog2(MEM_TIMEOUT+1).
- Cleared on every state entry.
- Increments each cycle spent in FETCH or MEM with mem_ready low.
- When the count reaches MEM_TIMEOUT−1 with mem_ready still low: set fault=10, go to HALT.
- mem_ready arriving in the same cycle as the count limit wins: the access completes and no fault is raised.

Other rules:
- mem_ready is ignored when mem_req=0.
- Exactly one pc_we pulse is issued per retired instruction.

## Timing
- Reset: state=FETCH, fault=00, instret=0, cycles=0, timeout counter=0, all strobes 0.
- The first mem_req is asserted in the first cycle after rst_n deasserts.
- Latency per instruction, with zero-wait memory (mem_ready high in the request cycle):
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - R, I, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle on the memory port adds one cycle.
- Reset asserted mid-instruction aborts it immediately. No partial retire is counted, and no strobe is produced after rst_n falls.

## Configuration
- SEQ_PERF_COUNTERS_EN defined:
  - cycles increments every cycle when not in reset, wrapping at 2^32.
  - instret increments on each retire (the pc_we cycle), wrapping at 2^32.
- SEQ_PERF_COUNTERS_EN undefined: instret and cycles are tied to 0 and no counter flops are built.

## Test plan
- **ADDI, zero-wait memory:** opcode=0010011, mem_ready=1 → states 0,1,2,4; rf_we and pc_we in cycle 4 with wb_sel=0, pc_sel=0; instret=1.
- **LW with 2-cycle data wait:** opcode=0000011, mem_ready low for 2 MEM cycles → 7 cycles total; wb_sel=1 in WB.
- **BEQ taken then not taken:** pc_sel=1 then 0 in EXECUTE; 3 cycles each; rf_we never asserted.
- **Fetch timeout:** mem_ready held 0 with MEM_TIMEOUT=4 → HALT after 4 FETCH cycles, fault=10, all strobes 0 until reset.
- **Illegal opcode:** opcode=1111111 → HALT after DECODE, fault=01.
- **Reset mid-MEM:** drop rst_n during a store → strobes 0 immediately; after release, state=0 and counters=0 (with SEQ_PERF_COUNTERS_EN defined).
